// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder.
// - MODE_ADD / MODE_SUB: encodings of the sub input.
// - num_stages(): pipeline depth for a WIDTH/CHUNK pair.
// - params_legal(): WIDTH must be a nonzero multiple of CHUNK.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic bit params_legal(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit slice of the pipelined adder.
// Adds slice IDX of in_a/in_b plus in_carry, merges the slice result into the running sum,
// and registers everything (valid, carry, operands, sum, slice overflow) when en is high.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   en                    advance the pipeline this cycle
//   in_valid, in_carry    beat valid and carry from the previous stage
//   in_a, in_b, in_sum    full-width operands (b already inverted for subtract), partial sum
//   out_valid, out_carry  registered valid and carry out of this slice
//   out_ovf               registered carry-into-slice-MSB XOR carry-out (meaningful on last slice)
//   out_a, out_b, out_sum registered operand and partial-sum pass-through
module adder_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_carry,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  output logic             out_valid,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum
);

  localparam int unsigned Lsb = IDX * CHUNK;
  localparam int unsigned Msb = Lsb + CHUNK - 1;

  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] sum_d;
  logic             carry_into_msb;

  always_comb begin
    slice_sum = {1'b0, in_a[Lsb +: CHUNK]} + {1'b0, in_b[Lsb +: CHUNK]}
              + {{CHUNK{1'b0}}, in_carry};
    sum_d = in_sum;
    sum_d[Lsb +: CHUNK] = slice_sum[CHUNK-1:0];
    // Recover the carry into the slice MSB from the MSB's sum bit.
    carry_into_msb = in_a[Msb] ^ in_b[Msb] ^ slice_sum[CHUNK-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sum   <= '0;
    end else if (en) begin
      // Bubbles load like data so every stage shifts in lockstep.
      out_valid <= in_valid;
      out_carry <= slice_sum[CHUNK];
      out_ovf   <= slice_sum[CHUNK] ^ carry_into_msb;
      out_a     <= in_a;
      out_b     <= in_b;
      out_sum   <= sum_d;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined carry-chain adder/subtractor with valid/ready on both sides.
// WIDTH bits are added CHUNK bits per stage over STAGES = WIDTH/CHUNK cycles; throughput is
// one beat per cycle. The whole pipe stalls together when the output is held.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   input handshake (in_ready is combinational from out_ready)
//   a, b, cin, sub       operands; sub=0: a+b+cin, sub=1: a-b (cin ignored)
//   out_valid, out_ready output handshake
//   sum, cout, ovf       result, carry out of MSB, signed overflow
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);

  if (!params_legal(WIDTH, CHUNK)) begin : gen_bad_params
    $error("pipelined_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  logic                         adv;
  logic [STAGES:0]              v_pipe;
  logic [STAGES:0]              c_pipe;
  logic [STAGES-1:0]            ovf_pipe;
  logic [STAGES:0][WIDTH-1:0]   a_pipe;
  logic [STAGES:0][WIDTH-1:0]   b_pipe;
  logic [STAGES:0][WIDTH-1:0]   s_pipe;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 0 inputs: subtract is a + ~b + 1, so the mode bit becomes the carry-in.
  assign v_pipe[0] = in_valid;
  assign c_pipe[0] = (sub == MODE_SUB) ? 1'b1 : cin;
  assign a_pipe[0] = a;
  assign b_pipe[0] = (sub == MODE_SUB) ? ~b : b;
  assign s_pipe[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (v_pipe[k]),
      .in_carry  (c_pipe[k]),
      .in_a      (a_pipe[k]),
      .in_b      (b_pipe[k]),
      .in_sum    (s_pipe[k]),
      .out_valid (v_pipe[k+1]),
      .out_carry (c_pipe[k+1]),
      .out_ovf   (ovf_pipe[k]),
      .out_a     (a_pipe[k+1]),
      .out_b     (b_pipe[k+1]),
      .out_sum   (s_pipe[k+1])
    );
  end

  assign out_valid = v_pipe[STAGES];
  assign sum       = s_pipe[STAGES];
  assign cout      = c_pipe[STAGES];
  assign ovf       = ovf_pipe[STAGES-1];

  // Operands leaving the last stage and earlier slices' overflow flags have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_pipe[STAGES], b_pipe[STAGES], ovf_pipe};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: 32/8, 8/8 and 64/4 instances share the stimulus.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, cin, sub, out_ready;
  logic [63:0] a, b;

  logic        in_ready32, out_valid32, cout32, ovf32;
  logic [31:0] sum32;
  logic        in_ready8, out_valid8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        in_ready64, out_valid64, cout64, ovf64;
  logic [63:0] sum64;

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .a(a[31:0]),
    .b(b[31:0]), .cin(cin), .sub(sub), .out_valid(out_valid32), .out_ready(out_ready),
    .sum(sum32), .cout(cout32), .ovf(ovf32)
  );
  pipelined_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .a(a[7:0]),
    .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(out_valid8), .out_ready(out_ready),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );
  pipelined_adder #(.WIDTH(64), .CHUNK(4)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .a(a),
    .b(b), .cin(cin), .sub(sub), .out_valid(out_valid64), .out_ready(out_ready),
    .sum(sum64), .cout(cout64), .ovf(ovf64)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [65:0] q32[$], q8[$], q64[$];
  logic [65:0] last32, last8, last64;
  int pop_cyc32, pop_cyc8, pop_cyc64;
  logic last_acc32;

  // Reference: whole-width add, result packed as {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic c, input logic s);
    logic [63:0] wmask, lmask, xm, ym;
    logic [64:0] full, low;
    logic        c0, co, cm;
    wmask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    lmask = wmask >> 1;
    xm    = x & wmask;
    ym    = (s ? ~y : y) & wmask;
    c0    = s ? 1'b1 : c;
    full  = {1'b0, xm} + {1'b0, ym} + {64'd0, c0};
    co    = full[w];
    low   = {1'b0, xm & lmask} + {1'b0, ym & lmask} + {64'd0, c0};
    cm    = low[w-1];
    return {co ^ cm, co, full[63:0] & wmask};
  endfunction

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes just before the edge, then step to 1ns after it.
  task automatic tick();
    logic acc32, acc8, acc64, pop32, pop8, pop64;
    logic [65:0] o32, o8, o64;
    @(negedge clk);
    acc32 = in_valid && in_ready32;
    acc8  = in_valid && in_ready8;
    acc64 = in_valid && in_ready64;
    pop32 = out_valid32 && out_ready;
    pop8  = out_valid8 && out_ready;
    pop64 = out_valid64 && out_ready;
    o32   = {ovf32, cout32, 32'd0, sum32};
    o8    = {ovf8, cout8, 56'd0, sum8};
    o64   = {ovf64, cout64, sum64};
    last_acc32 = acc32 && !rst;
    if (!rst) begin
      if (pop32) begin
        check("out32_expected", 66'(q32.size() != 0), 66'd1);
        if (q32.size() != 0) check("out32", o32, q32.pop_front());
        last32 = o32; pop_cyc32 = cyc;
      end
      if (pop8) begin
        check("out8_expected", 66'(q8.size() != 0), 66'd1);
        if (q8.size() != 0) check("out8", o8, q8.pop_front());
        last8 = o8; pop_cyc8 = cyc;
      end
      if (pop64) begin
        check("out64_expected", 66'(q64.size() != 0), 66'd1);
        if (q64.size() != 0) check("out64", o64, q64.pop_front());
        last64 = o64; pop_cyc64 = cyc;
      end
      if (acc32) q32.push_back(model(32, a, b, cin, sub));
      if (acc8)  q8.push_back(model(8, a, b, cin, sub));
      if (acc64) q64.push_back(model(64, a, b, cin, sub));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      q32.delete(); q8.delete(); q64.delete();
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (q32.size() + q8.size() + q64.size()) != 0; i++) tick();
    check({tag, "_drained"}, 66'(q32.size() + q8.size() + q64.size()), 66'd0);
  endtask

  task automatic new_data();
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  // One isolated beat through all three widths; checks hand-computed results and latency.
  task automatic run_single(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                            input logic tc, input logic ts, input logic [65:0] e32,
                            input logic [65:0] e8, input logic [65:0] e64);
    int t0;
    pop_cyc32 = -1; pop_cyc8 = -1; pop_cyc64 = -1;
    last32 = 'x; last8 = 'x; last64 = 'x;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    t0 = cyc;
    tick();
    in_valid = 1'b0;
    drain(tag, 40);
    check({tag, "_lat32"}, 66'(pop_cyc32 - t0), 66'd4);
    check({tag, "_lat8"},  66'(pop_cyc8 - t0),  66'd1);
    check({tag, "_lat64"}, 66'(pop_cyc64 - t0), 66'd16);
    check({tag, "_res32"}, last32, e32);
    check({tag, "_res8"},  last8,  e8);
    check({tag, "_res64"}, last64, e64);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] snap;
    int t0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("reset32", {out_valid32, ovf32, cout32, 32'd0, sum32}, 66'd0);
    check("reset8",  {out_valid8, ovf8, cout8, 56'd0, sum8}, 66'd0);
    check("reset64", {ovf64, cout64, sum64}, 66'd0);
    check("reset64_valid", 66'(out_valid64), 66'd0);
    rst = 1'b0; out_ready = 1'b0;
    #1;
    check("ready_after_reset", 66'(in_ready32), 66'd1);
    out_ready = 1'b1;

    // Directed: {ovf, cout, sum}
    run_single("wrap", 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0,
               {2'b01, 64'h0}, {2'b01, 64'h0}, {2'b00, 64'h1_0000_0000});
    run_single("sub_neg", 64'h5, 64'h7, 1'b0, 1'b1,
               {2'b00, 64'hFFFF_FFFE}, {2'b00, 64'hFE}, {2'b00, 64'hFFFF_FFFF_FFFF_FFFE});
    run_single("sub_ovf", 64'h7FFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b1,
               {2'b10, 64'h8000_0000}, {2'b01, 64'h0}, {2'b00, 64'hFFFF_FFFF_8000_0000});
    run_single("add_cin", 64'h1, 64'h2, 1'b1, 1'b0,
               {2'b00, 64'h4}, {2'b00, 64'h4}, {2'b00, 64'h4});
    run_single("sub_cin_ignored", 64'h9, 64'h3, 1'b1, 1'b1,
               {2'b01, 64'h6}, {2'b01, 64'h6}, {2'b01, 64'h6});
    run_single("add_ovf64", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               {2'b01, 64'h0}, {2'b01, 64'h0}, {2'b10, 64'h8000_0000_0000_0000});

    // Stream 16 back-to-back beats with mixed modes.
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      new_data();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    drain("stream", 40);
    check("stream_last32", 66'(pop_cyc32 - t0), 66'd19);
    check("stream_last8",  66'(pop_cyc8 - t0),  66'd16);
    check("stream_last64", 66'(pop_cyc64 - t0), 66'd31);

    // Fill with out_ready low, hold, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    new_data();
    for (int i = 0; i < 20 && !out_valid32; i++) begin
      tick();
      if (last_acc32) new_data();
    end
    check("stall_full", 66'(out_valid32), 66'd1);
    snap = sum32;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_in_ready", 66'(in_ready32), 66'd0);
      check("stall_sum", 66'(sum32), 66'(snap));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    drain("stall", 60);

    // Reset with beats in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      new_data();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("flush_valid32", 66'(out_valid32), 66'd0);
    check("flush_valid64", 66'(out_valid64), 66'd0);
    repeat (25) tick();
    check("flush_quiet32", 66'(out_valid32), 66'd0);
    run_single("post_flush", 64'h10, 64'h20, 1'b0, 1'b0,
               {2'b00, 64'h30}, {2'b00, 64'h30}, {2'b00, 64'h30});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
